// File: rtl/qos_pkg.sv
// Types and constants shared by the QoS egress path: port indices, scheduler
// state encoding and the round-robin search helper.
package qos_pkg;

   localparam int NPORT  = 4;
   localparam int DATA_W = 12;

   typedef logic [1:0] port_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE  = 2'd1,
      ROTATE = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic      found;
      port_idx_t idx;
   } port_pick_t;

   // First non-empty port at or after start, wrapping modulo NPORT.
   function automatic port_pick_t pick_first(input logic [NPORT-1:0] empty,
                                             input port_idx_t        start);
      port_pick_t pick;
      port_idx_t  cand;
      pick = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         cand = start + port_idx_t'(i);
         if (!empty[cand]) begin
            pick.found = 1'b1;
            pick.idx   = cand;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/egress_skid_buf.sv
// Two-entry FIFO-ordered output buffer that holds words arriving from the FIFO
// read pipeline until the downstream valid/ready handshake takes them.
module egress_skid_buf #(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        wr_port,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        rd_port,
   output logic [1:0]        occ
);
   import qos_pkg::*;

   logic [DATA_W-1:0] data_q [2];
   port_idx_t         port_q [2];
   logic              head;
   logic              wr_slot;
   logic              fire;

   assign rd_valid = (occ != 2'd0);
   assign rd_data  = data_q[head];
   assign rd_port  = port_q[head];
   assign fire     = rd_valid & rd_ready;
   // occ never reaches 2 on a write cycle, so head+occ mod 2 is always a free slot
   assign wr_slot  = head ^ occ[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '{default: '0};
         port_q <= '{default: '0};
         head   <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (wr_en) begin
            data_q[wr_slot] <= wr_data;
            port_q[wr_slot] <= wr_port;
         end
         if (fire) head <= ~head;
         occ <= occ + {1'b0, wr_en} - {1'b0, fire};
      end
   end

endmodule

// File: rtl/egress_scheduler.sv
// Round-robin, burst-limited pop scheduler merging four QoS output FIFOs into
// one valid/ready stream. Per-port fire counters exist only with EGRESS_STATS_EN.
//
// state  | meaning
// IDLE   | no grant; waiting for any non-empty FIFO
// SERVE  | popping the granted FIFO while the buffer has room
// ROTATE | one-cycle hand-off: advance rr pointer, clear burst, pick next port
module egress_scheduler #(
   parameter int DATA_W = 12,
   parameter int BURST  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        fifo_empty,
   input  logic [DATA_W-1:0] fifo_data0,
   input  logic [DATA_W-1:0] fifo_data1,
   input  logic [DATA_W-1:0] fifo_data2,
   input  logic [DATA_W-1:0] fifo_data3,
   output logic [3:0]        fifo_pop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_port,
   output logic              idle,
   input  logic [1:0]        stat_idx,
   output logic [CNT_W-1:0]  stat_count
);
   import qos_pkg::*;

   sched_state_t      state, state_nxt;
   port_idx_t         grant, grant_nxt;
   port_idx_t         rr_ptr, rr_nxt;
   port_idx_t         search_start;
   port_idx_t         inflight_idx;
   port_pick_t        pick;
   logic [3:0]        burst_cnt, burst_nxt;
   logic              pop_en, pop_any, pop_ok;
   logic              inflight, fire;
   logic [1:0]        occ;
   logic [2:0]        pending;
   logic [DATA_W-1:0] rd_word;

   assign fire    = out_valid & out_ready;
   assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, fire};
   assign pop_ok  = (pending <= 3'd1);

   // ROTATE searches from the pointer it is about to write, not the stale one
   assign search_start = (state == ROTATE) ? port_idx_t'(grant + 2'd1) : rr_ptr;
   assign pick         = pick_first(fifo_empty, search_start);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      burst_nxt = burst_cnt;
      pop_en    = 1'b0;
      case (state)
         IDLE: begin
            if (pick.found) begin
               grant_nxt = pick.idx;
               state_nxt = SERVE;
            end
         end
         SERVE: begin
            if (!fifo_empty[grant] && pop_ok) begin
               pop_en    = 1'b1;
               burst_nxt = burst_cnt + 4'd1;
               if (burst_nxt == 4'(BURST)) state_nxt = ROTATE;
            end else if (fifo_empty[grant]) begin
               state_nxt = ROTATE;
            end
         end
         ROTATE: begin
            rr_nxt    = grant + 2'd1;
            burst_nxt = 4'd0;
            if (pick.found) begin
               grant_nxt = pick.idx;
               state_nxt = SERVE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A pop during the reset cycle would lose a word, so it is suppressed
   assign fifo_pop = (pop_en && !reset) ? (4'b0001 << grant) : 4'b0000;
   assign pop_any  = |fifo_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         grant        <= '0;
         rr_ptr       <= '0;
         burst_cnt    <= '0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         rr_ptr    <= rr_nxt;
         burst_cnt <= burst_nxt;
         inflight  <= pop_any;
         if (pop_any) inflight_idx <= grant;
      end
   end

   always_comb begin
      rd_word = fifo_data0;
      case (inflight_idx)
         2'd1:    rd_word = fifo_data1;
         2'd2:    rd_word = fifo_data2;
         2'd3:    rd_word = fifo_data3;
         default: rd_word = fifo_data0;
      endcase
   end

   egress_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (inflight),
      .wr_data  (rd_word),
      .wr_port  (inflight_idx),
      .rd_ready (out_ready),
      .rd_valid (out_valid),
      .rd_data  (out_data),
      .rd_port  (out_port),
      .occ      (occ)
   );

   assign idle = (state == IDLE) && (occ == 2'd0) && !inflight;

`ifdef EGRESS_STATS_EN
   logic [CNT_W-1:0] stat_q [NPORT];

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_q <= '{default: '0};
      end else if (fire) begin
         stat_q[out_port] <= stat_q[out_port] + 1'b1;
      end
   end

   assign stat_count = stat_q[stat_idx];
`else
   logic unused_stat_idx;
   assign unused_stat_idx = ^stat_idx;
   assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_egress_scheduler.sv
// Self-checking bench for egress_scheduler: behavioural FIFO models feed the
// DUT, per-port expected queues are filled on load and consumed on each fire.
module tb_egress_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  fifo_empty;
   logic [3:0]  fifo_pop;
   logic [11:0] fdata [4] = '{default: '0};
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic [1:0]  out_port;
   logic        idle;
   logic [1:0]  stat_idx;
   logic [7:0]  stat_count;

   logic [11:0] mem [4][512];
   int          wr_cnt [4] = '{0, 0, 0, 0};
   int          rd_ptr [4] = '{0, 0, 0, 0};
   int          fired  [4] = '{0, 0, 0, 0};
   logic [11:0] exp_q  [4][$];

   logic [3:0]  tr [64];
   logic        ov [64];
   logic        id [64];
   logic [1:0]  st [64];
   logic [11:0] od [64];
   logic [1:0]  op [64];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   egress_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_data0 (fdata[0]),
      .fifo_data1 (fdata[1]),
      .fifo_data2 (fdata[2]),
      .fifo_data3 (fdata[3]),
      .fifo_pop   (fifo_pop),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_port   (out_port),
      .idle       (idle),
      .stat_idx   (stat_idx),
      .stat_count (stat_count)
   );

   for (genvar g = 0; g < 4; g++) begin : g_empty
      assign fifo_empty[g] = (rd_ptr[g] == wr_cnt[g]);
   end

   // FIFO model: data valid the cycle after the pop, empty flag moves on the pop edge
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (fifo_pop[i] && rd_ptr[i] < wr_cnt[i]) begin
            fdata[i]  <= mem[i][rd_ptr[i]];
            rd_ptr[i] <= rd_ptr[i] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Advance to the next falling edge and score whatever the DUT shows there.
   task automatic step();
      logic [11:0] want;
      @(negedge clk);
      if (fifo_pop != 4'b0000) begin
         check("pop_onehot", 32'($onehot(fifo_pop)), 1);
         for (int i = 0; i < 4; i++)
            if (fifo_pop[i]) check("pop_nonempty", 32'(fifo_empty[i]), 0);
      end
      if (out_valid && out_ready && !reset) begin
         if (exp_q[out_port].size() == 0) begin
            check("sb_extra_word", {20'b0, out_data}, 32'hFFFF_FFFF);
         end else begin
            want = exp_q[out_port].pop_front();
            check("sb_data", {20'b0, out_data}, {20'b0, want});
         end
         fired[out_port]++;
      end
   endtask

   task automatic load(input int p, input int n, input logic [11:0] base);
      for (int j = 0; j < n; j++) begin
         mem[p][wr_cnt[p]] = base + 12'(j);
         exp_q[p].push_back(base + 12'(j));
         wr_cnt[p]++;
      end
   endtask

   // Words popped but never fired were discarded by reset.
   task automatic resync();
      for (int i = 0; i < 4; i++) begin
         for (int k = fired[i]; k < rd_ptr[i]; k++)
            if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
         fired[i] = rd_ptr[i];
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      resync();
   endtask

   function automatic int remaining();
      int r = 0;
      for (int i = 0; i < 4; i++) r += exp_q[i].size();
      return r;
   endfunction

   task automatic drain(input string tag, input int limit);
      int k = 0;
      while ((!idle || remaining() != 0) && k < limit) begin
         step();
         k++;
      end
      check({tag, "_words_left"}, 32'(remaining()), 0);
      check({tag, "_idle"}, 32'(idle), 1);
   endtask

   task automatic wait_first_pop(input string tag);
      int k = 0;
      while (fifo_pop == 4'b0000 && k < 100) begin
         step();
         k++;
      end
      check({tag, "_pop_seen"}, 32'(fifo_pop != 4'b0000), 1);
   endtask

   task automatic record(input int n);
      for (int j = 0; j < n; j++) begin
         tr[j] = fifo_pop;
         ov[j] = out_valid;
         id[j] = idle;
         st[j] = dut.state;
         od[j] = out_data;
         op[j] = out_port;
         step();
      end
   endtask

   initial begin
      logic [3:0]  exp_tr [$];
      logic [3:0]  late_pops;
      logic [11:0] held;

      out_ready = 1'b1;
      stat_idx  = 2'd0;
      reset     = 1'b1;
      repeat (3) step();
      check("rst_pop", 32'(fifo_pop), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_idle", 32'(idle), 1);
      check("rst_data", 32'(out_data), 0);
      check("rst_port", 32'(out_port), 0);
      reset = 1'b0;
      step();

      // single port, three words
      load(2, 3, 12'h201);
      wait_first_pop("single");
      record(6);
      for (int j = 0; j < 6; j++)
         check("single_pop", 32'(tr[j]), (j < 3) ? 32'h4 : 32'h0);
      check("single_lat0", 32'(ov[0]), 0);
      check("single_lat1", 32'(ov[1]), 0);
      check("single_lat2", 32'(ov[2]), 1);
      check("single_first_word", 32'(od[2]), 32'h201);
      check("single_first_port", 32'(op[2]), 2);
      check("single_third_word", 32'(od[4]), 32'h203);
      check("single_rotate", 32'(st[4]), 2);
      check("single_to_idle", 32'(st[5]), 0);
      check("single_idle_flag", 32'(id[5]), 1);
      drain("single", 200);

      // all four ports, six words each: bursts of 4 with one-cycle gaps
      do_reset();
      for (int p = 0; p < 4; p++) load(p, 6, 12'((p << 8) | 'h10));
      wait_first_pop("rr");
      record(22);
      exp_tr.delete();
      for (int p = 0; p < 4; p++) begin
         repeat (4) exp_tr.push_back(4'(1 << p));
         exp_tr.push_back(4'h0);
      end
      repeat (2) exp_tr.push_back(4'h1);
      for (int j = 0; j < 22; j++) check("rr_pop_seq", 32'(tr[j]), 32'(exp_tr[j]));
      drain("rr", 400);

      // backpressure mid-burst
      do_reset();
      load(0, 8, 12'h050);
      wait_first_pop("bp");
      step();
      step();
      out_ready = 1'b0;
      repeat (3) step();
      held      = out_data;
      late_pops = 4'b0000;
      for (int j = 0; j < 7; j++) begin
         step();
         late_pops |= fifo_pop;
         check("bp_head_stable", 32'(out_data), 32'(held));
      end
      check("bp_occ", 32'(dut.occ), 2);
      check("bp_no_pop", 32'(late_pops), 0);
      check("bp_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      drain("bp", 400);

      // port 1 runs dry before its burst limit
      do_reset();
      load(1, 2, 12'h110);
      load(2, 3, 12'h220);
      wait_first_pop("dry");
      record(7);
      exp_tr.delete();
      exp_tr = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
      for (int j = 0; j < 7; j++) check("dry_pop_seq", 32'(tr[j]), 32'(exp_tr[j]));
      drain("dry", 200);

      // reset while the buffer is full
      do_reset();
      out_ready = 1'b0;
      load(3, 4, 12'h330);
      repeat (8) step();
      check("full_occ", 32'(dut.occ), 2);
      reset = 1'b1;
      step();
      check("rstfull_valid", 32'(out_valid), 0);
      check("rstfull_occ", 32'(dut.occ), 0);
      check("rstfull_idle", 32'(idle), 1);
      reset = 1'b0;
      resync();
      out_ready = 1'b1;
      drain("rstfull", 200);

      // statistics over 300 fires from port 3
      do_reset();
      load(3, 300, 12'h100);
      drain("stats", 2000);
      stat_idx = 2'd3;
      step();
`ifdef EGRESS_STATS_EN
      check("stat_p3", 32'(stat_count), 44);
      for (int p = 0; p < 3; p++) begin
         stat_idx = 2'(p);
         step();
         check("stat_other", 32'(stat_count), 0);
      end
`else
      check("stat_tied", 32'(stat_count), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/egress_scheduler.md
Name: egress_scheduler

Overview:
- Downstream consumer of the QoS block's four output FIFOs. It drives their pops and merges their 12-bit words into one valid/ready egress stream.
- Service order is round-robin with a per-grant burst limit.
- A 2-entry output buffer absorbs the 1-cycle FIFO read latency and downstream backpressure, so no word is lost or duplicated.
- Replaces the testbench-driven popBP0..popBP3 in the system top.

Parameters:
- DATA_W, 12, word width (matches QoS FIFO data).
- BURST, 4, max consecutive pops granted to one port before rotating (1..15).
- CNT_W, 8, width of per-port statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  4  empty flags of output FIFOs 0..3; a flag updates on the same edge as the pop that empties the FIFO.
- fifo_data0..fifo_data3  in  DATA_W each  FIFO read data; valid the cycle after the pop.
- fifo_pop  out  4  one-hot-or-zero pop strobes to FIFOs 0..3.
- out_valid  out  1  egress word available.
- out_ready  in  1  downstream accepts; fire = out_valid & out_ready.
- out_data  out  DATA_W  egress word.
- out_port  out  2  source FIFO index of out_data.
- idle  out  1  no grant active, nothing in flight, buffer empty.
- stat_idx  in  2  selects the statistics counter (EGRESS_STATS_EN only).
- stat_count  out  CNT_W  words fired from port stat_idx (EGRESS_STATS_EN only).

Behaviour:
- Reset values (all on the reset edge): fifo_pop=0, out_valid=0, out_data=0, out_port=0, idle=1, state=IDLE, grant=0, burst_cnt=0, occ=0, inflight=0. Reset mid-operation discards buffered and in-flight words; the FIFOs are not re-read.
- FSM states: IDLE, SERVE, ROTATE.
- IDLE -> SERVE: any fifo_empty bit low. grant = first non-empty port searching from rr_ptr upward, mod 4.
- SERVE:
  - Pop fifo_pop[grant] when fifo_empty[grant]=0 and pop_ok.
  - pop_ok is true when (occ + inflight - fire) <= 1.
  - burst_cnt increments on each pop.
- SERVE -> ROTATE when either condition holds:
  - a pop makes burst_cnt reach BURST;
  - fifo_empty[grant]=1 with no pop this cycle.
- ROTATE (exactly one cycle, no pop):
  - rr_ptr = grant+1 mod 4; burst_cnt=0.
  - Next grant = first non-empty port searching from rr_ptr, which can be the same port if it is the only non-empty one.
  - Go to SERVE if one is found, else IDLE.
- Backpressure during SERVE (pop_ok low) holds state and burst_cnt; it never forces rotation.
- Read pipeline:
  - inflight registers pop; the popped index is stored alongside it.
  - The next cycle, fifo_data[stored index] and the index are written into the 2-entry output buffer.
  - The buffer is FIFO-ordered; occ ranges 0..2 and never overflows, guaranteed by pop_ok.
  - out_valid = (occ != 0); out_data and out_port show the buffer head.
  - Head is stable while out_valid & !out_ready.
  - Simultaneous buffer write and fire in the same cycle: occ is unchanged.
- Minimum latency: pop at cycle t, out_valid at t+2. Sustained rate is 1 word/cycle while ready=1, except for one bubble per ROTATE.
- Never pops an empty FIFO; at most one pop bit high per cycle. Per-port word order is preserved.
- idle = (state==IDLE) & (occ==0) & !inflight.

Optional Feature:
- Macro EGRESS_STATS_EN.
- Defined:
  - Four CNT_W counters increment on fire for counter[out_port]; they wrap modulo 2^CNT_W.
  - stat_count = counter[stat_idx], combinational.
  - Counters clear on reset.
- Undefined: no counters; stat_count tied to 0; stat_idx ignored.

Decomposition:
- Shared package qos_pkg:
  - NPORT=4 and DATA_W=12.
  - FSM state encoding {IDLE=2'd0, SERVE=2'd1, ROTATE=2'd2}.
  - Port-index typedef (2 bits).
- One sub-module, egress_skid_buf: 2-entry output buffer with occ, write strobe, valid/ready head.
- Arbitration and FSM stay in egress_scheduler.

Test Plan:
- Reset → fifo_pop=0, out_valid=0, idle=1. Assert reset while occ=2 → the next cycle has out_valid=0 and occ=0.
- Only FIFO 2 holds 3 words 0x201,0x202,0x203, out_ready=1 → fifo_pop=4'b0100 for 3 cycles. Output is 0x201..0x203 on port 2 starting 2 cycles after the first pop, then ROTATE, then IDLE with idle=1.
- All four FIFOs hold 6 words, BURST=4 → pops port0 ×4, ROTATE, port1 ×4, ..., port3 ×4, then port0 ×2. One-cycle gap between bursts.
- out_ready=0 for 10 cycles mid-burst → exactly 2 words buffered, fifo_pop held 0. After release, no loss or duplication and order is preserved.
- Port 1 empties after 2 of its 4 allowed pops → ROTATE, grant moves to port 2. fifo_pop[1] is never asserted while fifo_empty[1]=1.
- EGRESS_STATS_EN, 300 words fired from port 3, CNT_W=8 → stat_idx=3 gives stat_count=44 (wrap); other ports read 0.
